// File: rtl/act_packer_pkg.sv
// Shared defaults and slot-index helper for the activation packer.
package act_packer_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned Z_DEF     = 8;
  localparam int unsigned FI_DEF    = 4;
  localparam int unsigned N_DEF     = 16;

  // Slot in the packed word that value k of beat b lands in.
  function automatic int unsigned slot_idx(input int unsigned b, input int unsigned k,
                                           input int unsigned z, input int unsigned fi);
    return b * (z / fi) + k;
  endfunction

endpackage

// File: rtl/act_packer_if.sv
// Beat-input / packed-word-output handshake bundle for act_packer.
interface act_packer_if #(
    parameter int unsigned width = act_packer_pkg::WIDTH_DEF,
    parameter int unsigned z     = act_packer_pkg::Z_DEF,
    parameter int unsigned fi    = act_packer_pkg::FI_DEF,
    parameter int unsigned n     = act_packer_pkg::N_DEF
) ();
    localparam int unsigned AW = ((n / z) > 1) ? $clog2(n / z) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [width*z/fi-1:0]   sigmoid_package;
    logic [width*z/fi-1:0]   sp_package;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [width*z-1:0]      act_word;
    logic [width*z-1:0]      sp_word;
    logic [AW-1:0]           out_addr;
    logic                    layer_done;

    modport slave (
        input  in_valid, sigmoid_package, sp_package, flush, out_ready,
        output in_ready, out_valid, act_word, sp_word, out_addr, layer_done
    );

    modport master (
        output in_valid, sigmoid_package, sp_package, flush, out_ready,
        input  in_ready, out_valid, act_word, sp_word, out_addr, layer_done
    );
endinterface

// File: rtl/act_packer_pack_stage.sv
// Packing buffer with beat counter; act_o/sp_o expose the buffer with the current beat merged in.
module act_packer_pack_stage
    import act_packer_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEF,
    parameter int unsigned z     = Z_DEF,
    parameter int unsigned fi    = FI_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  beat_i,
    input  logic                  flush_i,
    input  logic [width*z/fi-1:0] sig_i,
    input  logic [width*z/fi-1:0] sp_i,
    output logic                  last_o,
    output logic [width*z-1:0]    act_o,
    output logic [width*z-1:0]    sp_o
);
    localparam int unsigned PER = z / fi;
    localparam int unsigned BW  = (fi > 1) ? $clog2(fi) : 1;

    logic [BW-1:0]        cnt_q, cnt_d;
    logic [width*z-1:0]   act_q, act_d;
    logic [width*z-1:0]   sp_q,  sp_d;

    assign last_o = (cnt_q == BW'(fi - 1));
    assign act_o  = act_d;
    assign sp_o   = sp_d;

    always_comb begin
        cnt_d = cnt_q;
        act_d = act_q;
        sp_d  = sp_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (beat_i) begin
            for (int unsigned k = 0; k < PER; k++) begin
                act_d[slot_idx(32'(cnt_q), k, z, fi)*width +: width] = sig_i[k*width +: width];
                sp_d [slot_idx(32'(cnt_q), k, z, fi)*width +: width] = sp_i [k*width +: width];
            end
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            act_q <= '0;
            sp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
            sp_q  <= sp_d;
        end
    end
endmodule

// File: rtl/act_packer.sv
// Collects fi narrow beats into one z-wide word and hands it off through a holding output register.
module act_packer
    import act_packer_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEF,
    parameter int unsigned z     = Z_DEF,
    parameter int unsigned fi    = FI_DEF,
    parameter int unsigned n     = N_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    act_packer_if.slave  bus
);
    localparam int unsigned NW = n / z;
    localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;

    logic                 in_ready, beat_acc, word_done, drain, last_beat;
    logic [width*z-1:0]   pk_act, pk_sp;
    logic                 out_valid_q, out_valid_d;
    logic [width*z-1:0]   act_q, act_d, sp_q, sp_d;
    logic [AW-1:0]        addr_q, addr_d, wcnt_q, wcnt_d;

    // Stall only when the next beat would complete a word with nowhere to put it.
    assign drain     = out_valid_q && bus.out_ready;
    assign in_ready  = !(last_beat && out_valid_q && !bus.out_ready);
    assign beat_acc  = bus.in_valid && in_ready && !bus.flush;
    assign word_done = beat_acc && last_beat;

    act_packer_pack_stage #(.width(width), .z(z), .fi(fi)) u_pack (
        .clk     (clk),
        .reset_n (reset_n),
        .beat_i  (beat_acc),
        .flush_i (bus.flush),
        .sig_i   (bus.sigmoid_package),
        .sp_i    (bus.sp_package),
        .last_o  (last_beat),
        .act_o   (pk_act),
        .sp_o    (pk_sp)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        act_d       = act_q;
        sp_d        = sp_q;
        addr_d      = addr_q;
        wcnt_d      = wcnt_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            addr_d      = '0;
            wcnt_d      = '0;
        end else if (word_done) begin
            out_valid_d = 1'b1;
            act_d       = pk_act;
            sp_d        = pk_sp;
            addr_d      = wcnt_q;
            wcnt_d      = (wcnt_q == AW'(NW - 1)) ? '0 : wcnt_q + 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            act_q       <= '0;
            sp_q        <= '0;
            addr_q      <= '0;
            wcnt_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            act_q       <= act_d;
            sp_q        <= sp_d;
            addr_q      <= addr_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.act_word   = act_q;
    assign bus.sp_word    = sp_q;
    assign bus.out_addr   = addr_q;
    assign bus.layer_done = drain && (addr_q == AW'(NW - 1));
endmodule

// File: doc/act_packer.md
ACT_PACKER -- requirements
Module: act_packer

Interface
REQ-001 Parameter width, 16, bits per fixed-point value.
REQ-002 Parameter z, 8, values per packed output word; multiple of fi.
REQ-003 Parameter fi, 4, fan-in; input beats per output word.
REQ-004 Parameter n, 16, neurons per layer; multiple of z.
REQ-005 Port clk  input  1  sole clock; all state rising-edge.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port in_valid  input  1  input beat present.
REQ-008 Port in_ready  output  1  beat accepted when in_valid and in_ready both high.
REQ-009 Port sigmoid_package  input  width*z/fi  z/fi activations, value k at bits [width*(k+1)-1:width*k].
REQ-010 Port sp_package  input  width*z/fi  matching sigmoid-prime values.
REQ-011 Port flush  input  1  synchronous discard of partial word and counters.
REQ-012 Port out_valid  output  1  packed word available.
REQ-013 Port out_ready  input  1  consumer takes word when out_valid and out_ready both high.
REQ-014 Port act_word  output  width*z  packed activations.
REQ-015 Port sp_word  output  width*z  packed sigmoid-prime values.
REQ-016 Port out_addr  output  max(1,$clog2(n/z))  word index within layer.
REQ-017 Port layer_done  output  1  one-cycle pulse when last word of layer handed off.

Function
REQ-018 Beat b (0..fi-1) of a word SHALL write its value k to slot b*(z/fi)+k of both packing buffers.
REQ-019 Beat counter SHALL increment per accepted beat and wrap fi-1 -> 0; wrap marks word complete.
REQ-020 Complete word SHALL transfer to output register on the cycle after its last beat is accepted; out_valid rises that cycle (latency 1 from last beat).
REQ-021 Output register SHALL hold act_word, sp_word, out_addr stable while out_valid high and out_ready low.
REQ-022 Packing buffer and output register form two stages: collection of the next word SHALL proceed while output is held.
REQ-023 in_ready SHALL be low only when the packing buffer holds fi-1 beats and the output register is full and not being drained that cycle; otherwise high.
REQ-024 Simultaneous output handoff and incoming word completion SHALL load the new word with out_valid staying high, no bubble, no loss.
REQ-025 Word address counter SHALL increment per word loaded to output, wrapping n/z-1 -> 0.
REQ-026 layer_done SHALL pulse the cycle the word with out_addr = n/z-1 is accepted by the consumer.
REQ-027 flush SHALL clear beat counter, word address, and out_valid next cycle and has priority over a simultaneous input beat; buffer contents need not clear.
REQ-028 No arithmetic on data; values pass bit-exact.
REQ-029 in_valid with in_ready low SHALL not alter state.

Reset
REQ-030 reset_n low SHALL immediately clear beat counter, word address, out_valid, layer_done; act_word and sp_word reset to 0; in_ready high after release.
REQ-031 Reset mid-word SHALL discard partial data; first beat after release is beat 0 of word 0.

Structure
REQ-032 Shared package SHALL hold default width, z, fi, n and the slot-index helper function.
REQ-033 Single sub-module pack_stage (one packing buffer with beat counter) is natural; instantiated twice is not required.

Verification
REQ-034 fi=4, z=8, n=16, out_ready=1; beats {1,2},{3,4},{5,6},{7,8} -> one cycle after beat 4, out_valid=1, act_word slots 0..7 = 1..8, out_addr=0.
REQ-035 Eight beats continuous, out_ready=1 -> words at out_addr 0 then 1, layer_done pulses once with word 1 handoff, ninth word restarts out_addr=0.
REQ-036 out_ready=0 with continuous input -> in_ready drops after 3rd beat of second word, act_word unchanged; out_ready=1 -> both words delivered in order, none dropped.
REQ-037 flush after 2 beats, then 4 new beats {9..16} -> output word holds 9..16 at out_addr 0.
REQ-038 reset_n asserted mid-word and mid-hold -> out_valid=0, act_word=0 asynchronously; next four beats form word 0.
REQ-039 Output handoff coincides with next word's last beat -> out_valid stays 1, consecutive words, no gap.
